// File: rtl/alu_flag_stage_pkg.sv
// rtl/alu_flag_stage_pkg.sv - shared types and constants for the ALU flag stage
package alu_flag_stage_pkg;

   // Condition codes evaluated against the architectural FLAGS register
   localparam logic [3:0] COND_AL = 4'd0;   // always
   localparam logic [3:0] COND_EQ = 4'd1;   // ZF
   localparam logic [3:0] COND_NE = 4'd2;   // !ZF
   localparam logic [3:0] COND_LT = 4'd3;   // SF != OF
   localparam logic [3:0] COND_GE = 4'd4;   // SF == OF
   localparam logic [3:0] COND_GT = 4'd5;   // !ZF && SF == OF
   localparam logic [3:0] COND_LE = 4'd6;   // ZF || SF != OF
   localparam logic [3:0] COND_CS = 4'd7;   // CF
   localparam logic [3:0] COND_CC = 4'd8;   // !CF
   localparam logic [3:0] COND_VS = 4'd9;   // OF
   localparam logic [3:0] COND_VC = 4'd10;  // !OF
   localparam logic [3:0] COND_MI = 4'd11;  // SF
   localparam logic [3:0] COND_PL = 4'd12;  // !SF
   localparam logic [3:0] COND_HI = 4'd13;  // !CF && !ZF
   localparam logic [3:0] COND_LS = 4'd14;  // CF || ZF
   localparam logic [3:0] COND_NV = 4'd15;  // never

   // Bit positions inside the 4-bit FLAGS vector {OF,SF,ZF,CF}
   localparam int FLAG_OF = 3;
   localparam int FLAG_SF = 2;
   localparam int FLAG_ZF = 1;
   localparam int FLAG_CF = 0;

   // One buffered adder result
   typedef struct packed {
      logic [15:0] sum;
      logic [2:0]  dest;
      logic        of;
      logic        sf;
      logic        zf;
      logic        cf;
      logic        flag_we;
   } entry_t;

   // Pack an entry's flags into FLAGS bit order
   function automatic logic [3:0] entry_flags(input entry_t e);
      logic [3:0] f;
      f          = 4'b0000;
      f[FLAG_OF] = e.of;
      f[FLAG_SF] = e.sf;
      f[FLAG_ZF] = e.zf;
      f[FLAG_CF] = e.cf;
      return f;
   endfunction

endpackage

// File: rtl/alu_flag_stage_cond_eval.sv
// rtl/alu_flag_stage_cond_eval.sv - condition-code decoder over the FLAGS register
module cond_eval
   import alu_flag_stage_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       cond_true
);

   logic w_of, w_sf, w_zf, w_cf;

   assign w_of = flags[FLAG_OF];
   assign w_sf = flags[FLAG_SF];
   assign w_zf = flags[FLAG_ZF];
   assign w_cf = flags[FLAG_CF];

   // Decode the condition against the current flag values
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_AL: cond_true = 1'b1;
         COND_EQ: cond_true = w_zf;
         COND_NE: cond_true = !w_zf;
         COND_LT: cond_true = (w_sf != w_of);
         COND_GE: cond_true = (w_sf == w_of);
         COND_GT: cond_true = !w_zf && (w_sf == w_of);
         COND_LE: cond_true = w_zf || (w_sf != w_of);
         COND_CS: cond_true = w_cf;
         COND_CC: cond_true = !w_cf;
         COND_VS: cond_true = w_of;
         COND_VC: cond_true = !w_of;
         COND_MI: cond_true = w_sf;
         COND_PL: cond_true = !w_sf;
         COND_HI: cond_true = !w_cf && !w_zf;
         COND_LS: cond_true = w_cf || w_zf;
         COND_NV: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - 2-entry result buffer with retire-time FLAGS update
module alu_flag_stage
   import alu_flag_stage_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_sum,
   input  logic        in_of,
   input  logic        in_sf,
   input  logic        in_zf,
   input  logic        in_cf,
   input  logic        in_flag_we,
   input  logic [2:0]  in_dest,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic [2:0]  out_dest,
   input  logic        flags_ld,
   input  logic [3:0]  flags_in,
   output logic [3:0]  flags,
   input  logic [3:0]  cond,
   output logic        cond_true
);

   localparam logic [1:0] L_FULL = 2'(DEPTH);

   entry_t     r_mem [0:1];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic [3:0] r_flags;

   logic       w_push;
   logic       w_pop;
   entry_t     w_in;
   entry_t     w_head;

   assign w_in = '{sum: in_sum, dest: in_dest, of: in_of, sf: in_sf,
                   zf: in_zf, cf: in_cf, flag_we: in_flag_we};

   // Handshake status comes from the registered count only
   assign in_ready  = (r_count < L_FULL);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign w_head   = r_mem[r_rd_ptr];
   assign out_sum  = w_head.sum;
   assign out_dest = w_head.dest;
   assign flags    = r_flags;

   // Entry storage is written on push and needs no reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in;
   end

   // Pointer and occupancy bookkeeping; 1-bit pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         if (w_push && !w_pop)      r_count <= r_count + 2'd1;
         else if (!w_push && w_pop) r_count <= r_count - 2'd1;
      end
   end

   // FLAGS: direct load wins over the retiring entry's flag update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= 4'b0000;
      end else if (flags_ld) begin
         r_flags <= flags_in;
      end else if (w_pop && w_head.flag_we) begin
         r_flags <= entry_flags(w_head);
      end
   end

   cond_eval u_cond_eval (
      .flags     (r_flags),
      .cond      (cond),
      .cond_true (cond_true)
   );

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb/tb_alu_flag_stage.sv - self-checking bench for alu_flag_stage
module tb_alu_flag_stage;
   import alu_flag_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   entry_t      drv;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [2:0]  out_dest;
   logic        flags_ld;
   logic [3:0]  flags_in;
   logic [3:0]  flags;
   logic [3:0]  cond;
   logic        cond_true;

   int          n_checks = 0;
   int          n_errors = 0;
   entry_t      sb_q[$];
   logic [3:0]  exp_flags;

   typedef struct {
      logic [3:0] fl;
      logic [3:0] cc;
      logic       exp;
   } vec_t;
   vec_t vecs[25];

   always #5 clk = ~clk;

   alu_flag_stage #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (drv.sum),
      .in_of      (drv.of),
      .in_sf      (drv.sf),
      .in_zf      (drv.zf),
      .in_cf      (drv.cf),
      .in_flag_we (drv.flag_we),
      .in_dest    (drv.dest),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_dest   (out_dest),
      .flags_ld   (flags_ld),
      .flags_in   (flags_in),
      .flags      (flags),
      .cond       (cond),
      .cond_true  (cond_true)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic entry_t mk(input logic [15:0] s, input logic [2:0] d,
                                 input logic [3:0] f, input logic we);
      entry_t e;
      e.sum = s; e.dest = d;
      e.of = f[3]; e.sf = f[2]; e.zf = f[1]; e.cf = f[0];
      e.flag_we = we;
      return e;
   endfunction

   // One clock: called just after a falling edge with inputs already driven
   task automatic step();
      logic   push, pop;
      entry_t head;
      #1;
      chk("out_valid_vs_model", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("in_ready_vs_model", 32'(in_ready), 32'(sb_q.size() < 2));
      push = in_valid && in_ready;
      pop  = out_valid && out_ready;
      if (pop) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pop", 32'(1), 32'(0));
         end else begin
            head = sb_q.pop_front();
            chk("out_sum", 32'(out_sum), 32'(head.sum));
            chk("out_dest", 32'(out_dest), 32'(head.dest));
            if (!flags_ld && head.flag_we)
               exp_flags = {head.of, head.sf, head.zf, head.cf};
         end
      end
      if (flags_ld) exp_flags = flags_in;
      if (push) sb_q.push_back(drv);
      @(posedge clk);
      @(negedge clk);
      chk("flags", 32'(flags), 32'(exp_flags));
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      out_ready = 1'b0;
      flags_ld = 1'b0;
      flags_in = 4'b0000;
      drv = mk(16'h0000, 3'd0, 4'b0000, 1'b0);
   endtask

   task automatic drain();
      int budget;
      in_valid = 1'b0;
      out_ready = 1'b1;
      budget = 0;
      while (sb_q.size() != 0 && budget < 10) begin
         step();
         budget++;
      end
      chk("drain_done", 32'(sb_q.size()), 32'(0));
      out_ready = 1'b0;
   endtask

   initial begin
      entry_t vals[3];
      int     k;

      vecs[0]  = '{4'b0000, 4'd0,  1'b1};
      vecs[1]  = '{4'b0000, 4'd15, 1'b0};
      vecs[2]  = '{4'b0010, 4'd1,  1'b1};
      vecs[3]  = '{4'b0000, 4'd1,  1'b0};
      vecs[4]  = '{4'b0000, 4'd2,  1'b1};
      vecs[5]  = '{4'b1000, 4'd3,  1'b1};
      vecs[6]  = '{4'b1100, 4'd3,  1'b0};
      vecs[7]  = '{4'b1100, 4'd4,  1'b1};
      vecs[8]  = '{4'b0000, 4'd5,  1'b1};
      vecs[9]  = '{4'b0010, 4'd5,  1'b0};
      vecs[10] = '{4'b0010, 4'd6,  1'b1};
      vecs[11] = '{4'b0100, 4'd6,  1'b1};
      vecs[12] = '{4'b0000, 4'd6,  1'b0};
      vecs[13] = '{4'b0001, 4'd7,  1'b1};
      vecs[14] = '{4'b0001, 4'd8,  1'b0};
      vecs[15] = '{4'b1000, 4'd9,  1'b1};
      vecs[16] = '{4'b1000, 4'd10, 1'b0};
      vecs[17] = '{4'b0100, 4'd11, 1'b1};
      vecs[18] = '{4'b0100, 4'd12, 1'b0};
      vecs[19] = '{4'b0000, 4'd13, 1'b1};
      vecs[20] = '{4'b0001, 4'd13, 1'b0};
      vecs[21] = '{4'b0010, 4'd14, 1'b1};
      vecs[22] = '{4'b0000, 4'd14, 1'b0};
      vecs[23] = '{4'b1111, 4'd15, 1'b0};
      vecs[24] = '{4'b1111, 4'd0,  1'b1};

      // Reset state, observed before any clock edge
      rst = 1'b1;
      idle_inputs();
      cond = 4'd0;
      exp_flags = 4'b0000;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_flags", 32'(flags), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk);

      // Single push of a zero result with ZF, consumer always ready
      out_ready = 1'b1;
      in_valid = 1'b1;
      drv = mk(16'h0000, 3'd5, 4'b0010, 1'b1);
      step();
      in_valid = 1'b0;
      chk("s1_out_valid_after_push", 32'(out_valid), 32'(1));
      step();
      chk("s1_out_valid_one_cycle", 32'(out_valid), 32'(0));
      chk("s1_flags", 32'(flags), 32'(4'b0010));
      cond = 4'd1;
      #1;
      chk("s1_cond_eq", 32'(cond_true), 32'(1));
      out_ready = 1'b0;

      // Backpressure: three results offered, only two fit
      vals[0] = mk(16'h1111, 3'd1, 4'b0000, 1'b0);
      vals[1] = mk(16'h2222, 3'd2, 4'b0000, 1'b0);
      vals[2] = mk(16'h3333, 3'd3, 4'b0000, 1'b0);
      k = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         drv = vals[k];
         #1;
         if (in_ready) begin
            step();
            k++;
         end else begin
            step();
         end
      end
      chk("s2_pushes_accepted", 32'(k), 32'(2));
      chk("s2_in_ready_full", 32'(in_ready), 32'(0));
      chk("s2_head_held", 32'(out_sum), 32'(16'h1111));
      out_ready = 1'b1;
      for (int c = 0; c < 6 && k < 3; c++) begin
         drv = vals[k];
         #1;
         if (in_ready) k++;
         step();
      end
      chk("s2_all_pushed", 32'(k), 32'(3));
      drain();

      // Steady state at count=1 with simultaneous push and pop
      in_valid = 1'b1;
      drv = mk(16'hA000, 3'd0, 4'b0000, 1'b0);
      step();
      out_ready = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         drv = mk(16'hA000 + 16'(c), 3'(c), 4'b0000, 1'b0);
         step();
         chk("s3_count_one_valid", 32'(out_valid), 32'(1));
         chk("s3_count_one_ready", 32'(in_ready), 32'(1));
      end
      drain();

      // flags_ld wins over a retiring flag update
      in_valid = 1'b1;
      drv = mk(16'h0042, 3'd4, 4'b0001, 1'b1);
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      flags_ld = 1'b1;
      flags_in = 4'b1000;
      step();
      flags_ld = 1'b0;
      out_ready = 1'b0;
      chk("s4_flags_ld_priority", 32'(flags), 32'(4'b1000));
      cond = 4'd9;
      #1;
      chk("s4_cond_vs", 32'(cond_true), 32'(1));
      cond = 4'd3;
      #1;
      chk("s4_cond_lt", 32'(cond_true), 32'(1));
      @(negedge clk);

      // Retire with flag_we=0 leaves FLAGS alone
      flags_ld = 1'b1;
      flags_in = 4'b0000;
      step();
      flags_ld = 1'b0;
      in_valid = 1'b1;
      drv = mk(16'h0077, 3'd7, 4'b0001, 1'b0);
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("s5_flags_unchanged", 32'(flags), 32'(0));
      cond = 4'd7;
      #1;
      chk("s5_cond_cs", 32'(cond_true), 32'(0));
      @(negedge clk);

      // Condition decode table against directly loaded flags
      foreach (vecs[i]) begin
         flags_ld = 1'b1;
         flags_in = vecs[i].fl;
         step();
         flags_ld = 1'b0;
         cond = vecs[i].cc;
         #1;
         chk($sformatf("cond_vec%0d", i), 32'(cond_true), 32'(vecs[i].exp));
         @(negedge clk);
      end

      // Asynchronous reset with two entries buffered and FLAGS nonzero
      flags_ld = 1'b1;
      flags_in = 4'b0110;
      in_valid = 1'b1;
      drv = mk(16'hBEEF, 3'd6, 4'b1111, 1'b1);
      step();
      flags_ld = 1'b0;
      drv = mk(16'hCAFE, 3'd2, 4'b1111, 1'b1);
      step();
      in_valid = 1'b0;
      chk("s6_full_before_rst", 32'(in_ready), 32'(0));
      #2;
      rst = 1'b1;
      #1;
      chk("s6_rst_out_valid", 32'(out_valid), 32'(0));
      chk("s6_rst_flags", 32'(flags), 32'(0));
      sb_q.delete();
      exp_flags = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      chk("s6_no_pop_after_rst", 32'(flags), 32'(0));
      chk("s6_in_ready_after_rst", 32'(in_ready), 32'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: sim time %0t exceeded limit", $time);
      $fatal(1);
   end

endmodule
